// File: rtl/cu_mc_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Contents: controller state encoding, opcode map, PC-op and write-back mux codes.
package cu_mc_pkg;

    localparam int unsigned CU_OPW = 7;

    typedef enum logic [2:0] {
        ST_RST = 3'd0,
        ST_INF = 3'd1,
        ST_EX0 = 3'd2,
        ST_XL1 = 3'd3,
        ST_HLT = 3'd4,
        ST_ERR = 3'd5
    } cu_state_t;

    // Opcodes with non-default decode; every other value executes as an ALU op.
    typedef enum logic [CU_OPW-1:0] {
        OP_LD  = 7'b0010000,
        OP_IOR = 7'b0010001,
        OP_ST  = 7'b0100000,
        OP_IOW = 7'b0100001,
        OP_ADI = 7'b1000010,
        OP_LDI = 7'b1001100,
        OP_BRZ = 7'b1100000,
        OP_BRN = 7'b1100001,
        OP_JMP = 7'b1110000,
        OP_XXL = 7'b1111110,
        OP_HAL = 7'b1111111
    } opcode_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [1:0] MD_FU   = 2'b00;
    localparam logic [1:0] MD_MEM  = 2'b01;
    localparam logic [1:0] MD_IO   = 2'b10;

    localparam logic [3:0] FS_ZERO = 4'b0000;
    localparam logic [3:0] FS_XXL  = 4'b1110;

endpackage

// File: rtl/cu_mc_wait_ctr.sv
// cu_wait_ctr: up-counter with synchronous clear and a limit comparator.
// Ports: clk, rst_n (async active-low), i_en (count), i_clr (clear, wins over i_en),
//        i_limit (compare value), o_done_c (combinational: count equals limit).
module cu_wait_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic         o_done_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_done_c = (r_cnt == i_limit);

endmodule

// File: rtl/cu_mc.sv
// cu_mc: multi-cycle control unit. Decodes the instruction register into
// datapath / PC / memory controls, with a memory ready handshake, a bounded
// XXL loop state and sticky HLT (and, with CU_TIMEOUT_EN, ERR) states.
// Optional feature macro: CU_TIMEOUT_EN (wait-state timeout into ERR).
// Ports: clk, rst_n (async active-low); ins_in, z_in, n_in, mem_rdy_in in;
//        il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
//        wen_out (active low), iom_out, halted_out, err_out out (combinational).
module cu_mc
    import cu_mc_pkg::*;
#(
    parameter int unsigned IW     = 16,
    parameter int unsigned OPW    = CU_OPW,
    parameter int unsigned RAW    = 3,
    parameter int unsigned XL_MAX = 16
`ifdef CU_TIMEOUT_EN
    ,
    parameter int unsigned TO_LIM = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IW-1:0]        ins_in,
    input  logic                 z_in,
    input  logic                 n_in,
    input  logic                 mem_rdy_in,
    output logic                 il_out,
    output logic [1:0]           ps_out,
    output logic                 rw_out,
    output logic [3*(RAW+1)-1:0] rs_out,
    output logic                 mm_out,
    output logic [1:0]           md_out,
    output logic                 mb_out,
    output logic [3:0]           fs_out,
    output logic                 wen_out,
    output logic                 iom_out,
    output logic                 halted_out,
    output logic                 err_out
);

    localparam int unsigned XLW = $clog2(XL_MAX + 1);

    cu_state_t        r_state;
    cu_state_t        w_state_nxt;
    logic [OPW-1:0]   w_op;
    logic [RAW-1:0]   w_rd;
    logic [RAW-1:0]   w_ra;
    logic [RAW-1:0]   w_rb;
    logic             w_is_mem;
    logic             w_xl_en;
    logic             w_xl_done;
    logic             w_timeout;

    assign w_op = ins_in[IW-1 -: OPW];
    assign w_rd = ins_in[3*RAW-1 -: RAW];
    assign w_ra = ins_in[2*RAW-1 -: RAW];
    assign w_rb = ins_in[RAW-1:0];

    assign w_is_mem = (w_op == OPW'(OP_LD))  || (w_op == OPW'(OP_ST)) ||
                      (w_op == OPW'(OP_IOR)) || (w_op == OPW'(OP_IOW));

    // XL1 iteration counter; held at zero outside the loop state.
    assign w_xl_en = (r_state == ST_XL1);

    cu_wait_ctr #(.W(XLW)) u_xl_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_xl_en),
        .i_clr    (!w_xl_en),
        .i_limit  (XLW'(XL_MAX - 1)),
        .o_done_c (w_xl_done)
    );

`ifdef CU_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TO_LIM + 1);

    logic w_to_en;
    logic w_to_done;

    // Consecutive wait cycles in fetch or a stalled memory op; any ready clears it.
    assign w_to_en = !mem_rdy_in &&
                     ((r_state == ST_INF) || ((r_state == ST_EX0) && w_is_mem));

    cu_wait_ctr #(.W(TOW)) u_to_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_to_en),
        .i_clr    (!w_to_en),
        .i_limit  (TOW'(TO_LIM)),
        .o_done_c (w_to_done)
    );

    assign w_timeout = w_to_en && w_to_done;
    assign err_out   = (r_state == ST_ERR);
`else
    assign w_timeout = 1'b0;
    assign err_out   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RST: w_state_nxt = ST_INF;
            ST_INF: begin
                if (mem_rdy_in)     w_state_nxt = ST_EX0;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_EX0: begin
                if (w_is_mem) begin
                    if (mem_rdy_in)     w_state_nxt = ST_INF;
                    else if (w_timeout) w_state_nxt = ST_ERR;
                end else if (w_op == OPW'(OP_HAL)) begin
                    w_state_nxt = ST_HLT;
                end else if ((w_op == OPW'(OP_XXL)) && !z_in) begin
                    w_state_nxt = ST_XL1;
                end else begin
                    w_state_nxt = ST_INF;
                end
            end
            ST_XL1: begin
                if (z_in || w_xl_done) w_state_nxt = ST_INF;
            end
            ST_HLT:  w_state_nxt = ST_HLT;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_RST;
        endcase
    end

    // Output decode: Moore on state, Mealy on instruction, flags and ready.
    always_comb begin
        il_out     = 1'b0;
        ps_out     = PS_HOLD;
        rw_out     = 1'b0;
        rs_out     = '0;
        mm_out     = 1'b0;
        md_out     = MD_FU;
        mb_out     = 1'b0;
        fs_out     = FS_ZERO;
        wen_out    = 1'b1;
        iom_out    = 1'b0;
        halted_out = 1'b0;
        case (r_state)
            ST_INF: il_out = mem_rdy_in;
            ST_EX0: begin
                ps_out = PS_INC;
                rw_out = 1'b1;
                rs_out = {1'b0, w_rd, 1'b0, w_ra, 1'b0, w_rb};
                fs_out = w_op[3:0];
                case (w_op)
                    OPW'(OP_LD):  md_out = MD_MEM;
                    OPW'(OP_IOR): begin md_out = MD_IO; iom_out = 1'b1; end
                    OPW'(OP_ST):  begin rw_out = 1'b0; wen_out = 1'b0; end
                    OPW'(OP_IOW): begin rw_out = 1'b0; wen_out = 1'b0; iom_out = 1'b1; end
                    OPW'(OP_LDI), OPW'(OP_ADI): mb_out = 1'b1;
                    OPW'(OP_BRZ): begin rw_out = 1'b0; ps_out = z_in ? PS_BR : PS_INC; end
                    OPW'(OP_BRN): begin
                        rw_out = 1'b0;
                        ps_out = n_in ? PS_BR : PS_INC;
                        fs_out = FS_ZERO;
                    end
                    OPW'(OP_JMP): begin rw_out = 1'b0; ps_out = PS_JMP; end
                    OPW'(OP_HAL): begin rw_out = 1'b0; ps_out = PS_HOLD; end
                    OPW'(OP_XXL): begin
                        rw_out = 1'b0;
                        ps_out = PS_HOLD;
                        fs_out = FS_XXL;
                        rs_out = '0;
                        mm_out = 1'b1;
                    end
                    default: ;
                endcase
                // Stalled transfer: suppress side effects, keep the rest of the decode stable.
                if (w_is_mem && !mem_rdy_in) begin
                    rw_out  = 1'b0;
                    wen_out = 1'b1;
                    ps_out  = PS_HOLD;
                end
            end
            ST_XL1: begin
                rs_out = '0;
                mm_out = 1'b1;
                fs_out = FS_XXL;
                rw_out = 1'b1;
                ps_out = (z_in || w_xl_done) ? PS_INC : PS_HOLD;
            end
            ST_HLT:  halted_out = 1'b1;
            default: ;
        endcase
    end

endmodule
